// File: rtl/nn_pkg.sv
// Shared types, default word format and the pixel-to-fixed-point mapping for the NN front end.
// NN_LOADER_BINARIZE_EN selects thresholded 0 / 1.0 pixels instead of the linear pixel/256 mapping.
package nn_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} nn_state_t;

  localparam int DATA_WIDTH      = 16;
  localparam int DATA_FRAC_WIDTH = 8;

  // Result is wide; callers truncate to their word width.
  function automatic logic [31:0] pix_to_fixed(input logic [15:0] pix,
                                               input int frac_width,
                                               input int thresh);
`ifdef NN_LOADER_BINARIZE_EN
    return (int'(pix) >= thresh) ? (32'd1 << frac_width) : 32'd0;
`else
    return 32'(pix) << (frac_width - 8);
`endif
  endfunction

endpackage

// File: rtl/nn_pixel_convert.sv
// Combinational pixel -> fixed-point word conversion, shared by any pixel source.
// Variant (linear or binarized) follows NN_LOADER_BINARIZE_EN through nn_pkg::pix_to_fixed.
module nn_pixel_convert
  import nn_pkg::*;
#(
  parameter int pixWidth      = 8,
  parameter int dataWidth     = DATA_WIDTH,
  parameter int dataFracWidth = DATA_FRAC_WIDTH,
  parameter int binThreshold  = 128
) (
  input  logic [pixWidth-1:0]  pix,
  output logic [dataWidth-1:0] word
);

  assign word = dataWidth'(pix_to_fixed(16'(pix), dataFracWidth, binThreshold));

endmodule

// File: rtl/nn_frame_loader.sv
// Assembles a stream of pixels into one flat network input frame, fires it, then back-pressures
// until the network returns a result. NN_LOADER_BINARIZE_EN selects binarized pixel conversion.
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame
// LOAD  | writing pixels at pixCount
// FIRE  | frame complete, frameValid high this cycle
// WAIT  | frame held, waiting for resultValid
module nn_frame_loader
  import nn_pkg::*;
#(
  parameter int numInputs     = 784,
  parameter int dataWidth     = DATA_WIDTH,
  parameter int dataFracWidth = DATA_FRAC_WIDTH,
  parameter int pixWidth      = 8,
  parameter int binThreshold  = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [pixWidth-1:0]            pixIn,
  input  logic                           pixValid,
  input  logic                           pixSof,
  output logic                           pixReady,
  input  logic                           resultValid,
  output logic [dataWidth*numInputs-1:0] frameOut,
  output logic                           frameValid,
  output logic                           busy,
  output logic [$clog2(numInputs)-1:0]   pixCount,
  output logic                           sofErr
);

  localparam int CW = $clog2(numInputs);
  localparam logic [CW-1:0] LAST = CW'(numInputs - 1);

  nn_state_t            state, state_nxt;
  logic                 armed;
  logic                 accept, restart, last_pix;
  logic [CW-1:0]        wr_idx;
  logic [dataWidth-1:0] pix_word;

  assign accept   = pixValid && pixReady;
  assign restart  = (state == LOAD) && pixSof && (pixCount != '0);
  assign wr_idx   = ((state == IDLE) || restart) ? '0 : pixCount;
  assign last_pix = (state == LOAD) && !restart && (pixCount == LAST);

  nn_pixel_convert #(
    .pixWidth     (pixWidth),
    .dataWidth    (dataWidth),
    .dataFracWidth(dataFracWidth),
    .binThreshold (binThreshold)
  ) u_convert (
    .pix (pixIn),
    .word(pix_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    if (accept && last_pix) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      WAIT:    if (resultValid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // armed keeps pixReady low through reset and until the first clock afterwards.
  always_comb begin
    pixReady = armed && ((state == IDLE) || (state == LOAD));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      pixCount   <= '0;
      busy       <= 1'b0;
      frameValid <= 1'b0;
      sofErr     <= 1'b0;
    end else begin
      armed      <= 1'b1;
      frameValid <= accept && last_pix;
      sofErr     <= accept && restart;
      if (accept) pixCount <= last_pix ? '0 : wr_idx + CW'(1);
      if (accept && (state == IDLE))          busy <= 1'b1;
      else if ((state == WAIT) && resultValid) busy <= 1'b0;
    end
  end

  // Words of an aborted frame are intentionally left in place on a restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       frameOut <= '0;
    else if (accept) frameOut[wr_idx*dataWidth +: dataWidth] <= pix_word;
  end

endmodule

// File: tb/tb_nn_frame_loader.sv
// Self-checking bench for nn_frame_loader: write scoreboard drained and compared at each frameValid.
// Expected words follow NN_LOADER_BINARIZE_EN when that macro is defined for the build.
module tb_nn_frame_loader;

  localparam int N  = 784;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        pixIn = '0;
  logic              pixValid = 1'b0;
  logic              pixSof = 1'b0;
  logic              pixReady;
  logic              resultValid = 1'b0;
  logic [DW*N-1:0]   frameOut;
  logic              frameValid;
  logic              busy;
  logic [9:0]        pixCount;
  logic              sofErr;

  nn_frame_loader dut (
    .clk        (clk),
    .reset      (reset),
    .pixIn      (pixIn),
    .pixValid   (pixValid),
    .pixSof     (pixSof),
    .pixReady   (pixReady),
    .resultValid(resultValid),
    .frameOut   (frameOut),
    .frameValid (frameValid),
    .busy       (busy),
    .pixCount   (pixCount),
    .sofErr     (sofErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] val;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] mem [N];
  bit          m_loading = 0;
  int          m_count = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          fv_count = 0;

  always @(posedge clk) if (frameValid === 1'b1) fv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [7:0] p);
`ifdef NN_LOADER_BINARIZE_EN
    return (p >= 8'd128) ? 16'h0100 : 16'h0000;
`else
    return {8'h00, p};
`endif
  endfunction

  task automatic model_clear();
    wq.delete();
    for (int i = 0; i < N; i++) mem[i] = '0;
    m_loading = 0;
    m_count = 0;
  endtask

  task automatic model_accept(input logic [7:0] p, input logic sof);
    int idx;
    idx = (!m_loading || sof) ? 0 : m_count;
    wq.push_back('{idx, exp_word(p)});
    m_loading = 1;
    m_count = idx + 1;
    if (idx == N - 1) begin
      m_loading = 0;
      m_count = 0;
    end
  endtask

  // Returns just after the accepting edge.
  task automatic send_pix(input logic [7:0] p, input logic sof);
    int n = 0;
    @(negedge clk);
    pixIn = p; pixSof = sof; pixValid = 1'b1;
    while (pixReady !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (pixReady !== 1'b1) begin
      check("ready_timeout", {31'd0, pixReady}, 32'd1);
      pixValid = 1'b0; pixSof = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(p, sof);
    #1;
    pixValid = 1'b0; pixSof = 1'b0;
  endtask

  task automatic compare_frame(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_word%0d", tag, i), {16'd0, frameOut[i*DW +: DW]}, {16'd0, mem[i]});
  endtask

  // Called right after the last accept: frameValid must be high on the very next cycle only.
  task automatic finish_frame(input string tag);
    wr_t e;
    @(negedge clk);
    check({tag, "_fv"},       {31'd0, frameValid}, 32'd1);
    check({tag, "_rdy_fire"}, {31'd0, pixReady},   32'd0);
    check({tag, "_busy"},     {31'd0, busy},       32'd1);
    check({tag, "_cnt"},      {22'd0, pixCount},   32'd0);
    while (wq.size() > 0) begin
      e = wq.pop_front();
      mem[e.idx] = e.val;
    end
    compare_frame(tag);
    @(negedge clk);
    check({tag, "_fv_width"}, {31'd0, frameValid}, 32'd0);
    check({tag, "_rdy_wait"}, {31'd0, pixReady},   32'd0);
  endtask

  task automatic release_frame(input string tag);
    @(negedge clk);
    resultValid = 1'b1;
    pixValid = 1'b0;
    @(negedge clk);
    resultValid = 1'b0;
    check({tag, "_rdy_after_result"}, {31'd0, pixReady}, 32'd1);
    check({tag, "_busy_after_result"}, {31'd0, busy},    32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdy"},   {31'd0, pixReady},   32'd0);
    check({tag, "_fv"},    {31'd0, frameValid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_sof"},   {31'd0, sofErr},     32'd0);
    check({tag, "_cnt"},   {22'd0, pixCount},   32'd0);
    check({tag, "_frame"}, {31'd0, (frameOut == '0)}, 32'd1);
  endtask

  int snap;

  initial begin
    model_clear();
    #2;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rdy_before_edge", {31'd0, pixReady}, 32'd0);
    @(negedge clk);
    check("rdy_after_edge", {31'd0, pixReady}, 32'd1);

    // Full back-to-back frame
    for (int i = 0; i < N; i++) begin
      send_pix(8'(i % 256), i == 0);
      if (i == 0 || i == 400) check($sformatf("a_busy_%0d", i), {31'd0, busy}, 32'd1);
    end
    finish_frame("a");
    check("a_word300", {16'd0, frameOut[300*DW +: DW]}, {16'd0, exp_word(8'h2C)});

    // Back-pressure in WAIT
    @(negedge clk);
    pixValid = 1'b1; pixIn = 8'hAA; pixSof = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("bp_rdy", {31'd0, pixReady}, 32'd0);
      if (c == 49) check("bp_cnt", {22'd0, pixCount}, 32'd0);
    end
    compare_frame("bp");
    pixSof = 1'b0;
    release_frame("a");

    // Mid-frame restart, plus resultValid ignored while loading
    for (int i = 0; i < 100; i++) begin
      send_pix(8'((i * 7 + 3) % 256), i == 0);
      if (i == 49) begin
        @(negedge clk); resultValid = 1'b1;
        @(negedge clk); resultValid = 1'b0;
        check("b_rv_ignored_busy", {31'd0, busy}, 32'd1);
        check("b_rv_ignored_cnt", {22'd0, pixCount}, 32'd50);
      end
    end
    send_pix(8'h7F, 1'b1);
    @(negedge clk);
    check("b_soferr", {31'd0, sofErr}, 32'd1);
    check("b_cnt_restart", {22'd0, pixCount}, 32'd1);
    snap = fv_count;
    @(negedge clk);
    check("b_soferr_pulse", {31'd0, sofErr}, 32'd0);
    for (int j = 1; j < N; j++) begin
      if (j == N - 1) check("b_no_early_fv", fv_count, snap);
      send_pix(8'((j * 5) % 256), 1'b0);
    end
    finish_frame("b");
    check("b_word0", {16'd0, frameOut[DW-1:0]}, {16'd0, exp_word(8'h7F)});
    release_frame("b");

    // Gapped input, same content as frame a
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 9) < 5) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_pix(8'(i % 256), i == 0);
    end
    finish_frame("gap");
    release_frame("gap");

    // Async reset mid-load, between edges
    for (int i = 0; i < 400; i++) send_pix(8'((i * 3) % 256), i == 0);
    check("r_cnt400", {22'd0, pixCount}, 32'd400);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Frame after reset; leading pixels exercise the binarize threshold
    for (int i = 0; i < N; i++) begin
      logic [7:0] p;
      case (i)
        0: p = 8'd127;
        1: p = 8'd128;
        2: p = 8'd255;
        3: p = 8'd0;
        default: p = 8'((i * 11) % 256);
      endcase
      send_pix(p, i == 0);
    end
    finish_frame("d");
`ifdef NN_LOADER_BINARIZE_EN
    check("d_w0", {16'd0, frameOut[0*DW +: DW]}, 32'h0000);
    check("d_w1", {16'd0, frameOut[1*DW +: DW]}, 32'h0100);
    check("d_w2", {16'd0, frameOut[2*DW +: DW]}, 32'h0100);
    check("d_w3", {16'd0, frameOut[3*DW +: DW]}, 32'h0000);
`else
    check("d_w0", {16'd0, frameOut[0*DW +: DW]}, 32'h007F);
    check("d_w1", {16'd0, frameOut[1*DW +: DW]}, 32'h0080);
    check("d_w2", {16'd0, frameOut[2*DW +: DW]}, 32'h00FF);
    check("d_w3", {16'd0, frameOut[3*DW +: DW]}, 32'h0000);
`endif
    release_frame("d");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
